// File: rtl/fetch_bundle_issuer.sv
// Fetch bundle issuer: requests 3-word fetch blocks from instruction memory and presents them
// as up to three instruction slots, with static branch prediction and zero-bubble resume.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   imem_req_o, imem_addr_o         3-word read request, word-aligned base address
//   imem_rdata_0/1/2_i              words at addr, addr+4, addr+8, one cycle after the request
//   fetch_valid_o                   per-slot valid toward the instruction buffer
//   instruction_o_k, pc_o_k,
//   imm_o_k, branch_prediction_o_k  slot k contents (k = 0..2)
//   fetch_ready_i                   buffer accepts the presented bundle this cycle
//   flush_i, redirect_pc_i          redirect to a new fetch PC
module fetch_bundle_issuer #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  imem_req_o,
   output logic [DATA_WIDTH-1:0] imem_addr_o,
   input  logic [DATA_WIDTH-1:0] imem_rdata_0_i,
   input  logic [DATA_WIDTH-1:0] imem_rdata_1_i,
   input  logic [DATA_WIDTH-1:0] imem_rdata_2_i,
   output logic [2:0]            fetch_valid_o,
   output logic [DATA_WIDTH-1:0] instruction_o_0,
   output logic [DATA_WIDTH-1:0] instruction_o_1,
   output logic [DATA_WIDTH-1:0] instruction_o_2,
   output logic [DATA_WIDTH-1:0] pc_o_0,
   output logic [DATA_WIDTH-1:0] pc_o_1,
   output logic [DATA_WIDTH-1:0] pc_o_2,
   output logic [DATA_WIDTH-1:0] imm_o_0,
   output logic [DATA_WIDTH-1:0] imm_o_1,
   output logic [DATA_WIDTH-1:0] imm_o_2,
   output logic                  branch_prediction_o_0,
   output logic                  branch_prediction_o_1,
   output logic                  branch_prediction_o_2,
   input  logic                  fetch_ready_i,
   input  logic                  flush_i,
   input  logic [DATA_WIDTH-1:0] redirect_pc_i
);

   localparam logic [6:0]            OpJal     = 7'b1101111;
   localparam logic [6:0]            OpBranch  = 7'b1100011;
   localparam logic [DATA_WIDTH-1:0] Nop       = DATA_WIDTH'(32'h0000_0013);
   localparam logic [DATA_WIDTH-1:0] AlignMask = ~DATA_WIDTH'(3);

   typedef enum logic {StRun, StHold} state_e;

   state_e                       state_q;
   logic                         pending_q;
   logic [DATA_WIDTH-1:0]        fetch_pc_q;
   logic [DATA_WIDTH-1:0]        pending_pc_q;
   logic [2:0]                   hold_valid_q;
   logic [2:0][DATA_WIDTH-1:0]   hold_instr_q;
   logic [2:0][DATA_WIDTH-1:0]   hold_pc_q;
   logic [2:0][DATA_WIDTH-1:0]   hold_imm_q;
   logic [2:0]                   hold_pred_q;

   logic [2:0][DATA_WIDTH-1:0]   rdata;
   logic [2:0][DATA_WIDTH-1:0]   slot_pc;
   logic [2:0][DATA_WIDTH-1:0]   slot_imm;
   logic [2:0]                   slot_pred;
   logic [2:0]                   new_valid;
   logic [2:0][DATA_WIDTH-1:0]   new_instr;
   logic [2:0][DATA_WIDTH-1:0]   new_pc;
   logic [2:0][DATA_WIDTH-1:0]   new_imm;
   logic [2:0]                   new_pred;
   logic [DATA_WIDTH-1:0]        next_pc;

   logic [2:0]                   out_valid;
   logic [2:0][DATA_WIDTH-1:0]   out_instr;
   logic [2:0][DATA_WIDTH-1:0]   out_pc;
   logic [2:0][DATA_WIDTH-1:0]   out_imm;
   logic [2:0]                   out_pred;

   assign rdata = {imem_rdata_2_i, imem_rdata_1_i, imem_rdata_0_i};

   // Per-slot decode of the memory response; only meaningful while pending_q is set.
   always_comb begin
      for (int k = 0; k < 3; k++) begin
         slot_pc[k] = pending_pc_q + DATA_WIDTH'(4 * k);
         case (rdata[k][6:0])
            OpJal: begin
               slot_imm[k]  = {{(DATA_WIDTH-20){rdata[k][31]}}, rdata[k][19:12], rdata[k][20],
                               rdata[k][30:21], 1'b0};
               slot_pred[k] = 1'b1;
            end
            OpBranch: begin
               slot_imm[k]  = {{(DATA_WIDTH-12){rdata[k][31]}}, rdata[k][7], rdata[k][30:25],
                               rdata[k][11:8], 1'b0};
               // Backward branches are predicted taken.
               slot_pred[k] = rdata[k][31];
            end
            default: begin
               slot_imm[k]  = '0;
               slot_pred[k] = 1'b0;
            end
         endcase
      end
   end

   // Truncate after the first predicted-taken slot and pick the bundle's successor address.
   always_comb begin
      new_valid = 3'b111;
      next_pc   = pending_pc_q + DATA_WIDTH'(12);
      if (slot_pred[0]) begin
         new_valid = 3'b001;
         next_pc   = (slot_pc[0] + slot_imm[0]) & AlignMask;
      end else if (slot_pred[1]) begin
         new_valid = 3'b011;
         next_pc   = (slot_pc[1] + slot_imm[1]) & AlignMask;
      end else if (slot_pred[2]) begin
         next_pc   = (slot_pc[2] + slot_imm[2]) & AlignMask;
      end
      for (int k = 0; k < 3; k++) begin
         new_instr[k] = new_valid[k] ? rdata[k]     : Nop;
         new_pc[k]    = new_valid[k] ? slot_pc[k]   : '0;
         new_imm[k]   = new_valid[k] ? slot_imm[k]  : '0;
         new_pred[k]  = new_valid[k] & slot_pred[k];
      end
   end

   // Presented bundle; deliberately independent of fetch_ready_i.
   always_comb begin
      out_valid = '0;
      out_instr = {3{Nop}};
      out_pc    = '0;
      out_imm   = '0;
      out_pred  = '0;
      if (!reset && !flush_i) begin
         if (state_q == StHold) begin
            out_valid = hold_valid_q;
            out_instr = hold_instr_q;
            out_pc    = hold_pc_q;
            out_imm   = hold_imm_q;
            out_pred  = hold_pred_q;
         end else if (pending_q) begin
            out_valid = new_valid;
            out_instr = new_instr;
            out_pc    = new_pc;
            out_imm   = new_imm;
            out_pred  = new_pred;
         end
      end
   end

   // All stored PCs are word-aligned, so the request address never carries low bits.
   always_comb begin
      imem_req_o  = 1'b0;
      imem_addr_o = fetch_pc_q;
      if (!reset && !flush_i) begin
         case (state_q)
            StRun: begin
               if (pending_q) begin
                  imem_req_o  = fetch_ready_i;
                  imem_addr_o = next_pc;
               end else begin
                  imem_req_o  = 1'b1;
               end
            end
            StHold:  imem_req_o = fetch_ready_i;
            default: imem_req_o = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StRun;
         pending_q    <= 1'b0;
         fetch_pc_q   <= RESET_PC & AlignMask;
         pending_pc_q <= '0;
         hold_valid_q <= '0;
         hold_instr_q <= '0;
         hold_pc_q    <= '0;
         hold_imm_q   <= '0;
         hold_pred_q  <= '0;
      end else if (flush_i) begin
         fetch_pc_q <= redirect_pc_i & AlignMask;
         pending_q  <= 1'b0;
         state_q    <= StRun;
      end else begin
         case (state_q)
            StRun: begin
               if (!pending_q) begin
                  pending_q    <= 1'b1;
                  pending_pc_q <= fetch_pc_q;
               end else if (fetch_ready_i) begin
                  pending_pc_q <= next_pc;
               end else begin
                  hold_valid_q <= new_valid;
                  hold_instr_q <= new_instr;
                  hold_pc_q    <= new_pc;
                  hold_imm_q   <= new_imm;
                  hold_pred_q  <= new_pred;
                  fetch_pc_q   <= next_pc;
                  pending_q    <= 1'b0;
                  state_q      <= StHold;
               end
            end
            StHold: begin
               if (fetch_ready_i) begin
                  pending_q    <= 1'b1;
                  pending_pc_q <= fetch_pc_q;
                  state_q      <= StRun;
               end
            end
            default: state_q <= StRun;
         endcase
      end
   end

   assign fetch_valid_o         = out_valid;
   assign instruction_o_0       = out_instr[0];
   assign instruction_o_1       = out_instr[1];
   assign instruction_o_2       = out_instr[2];
   assign pc_o_0                = out_pc[0];
   assign pc_o_1                = out_pc[1];
   assign pc_o_2                = out_pc[2];
   assign imm_o_0               = out_imm[0];
   assign imm_o_1               = out_imm[1];
   assign imm_o_2               = out_imm[2];
   assign branch_prediction_o_0 = out_pred[0];
   assign branch_prediction_o_1 = out_pred[1];
   assign branch_prediction_o_2 = out_pred[2];

endmodule

// File: doc/fetch_bundle_issuer.md
FETCH_BUNDLE_ISSUER -- requirements
Module: fetch_bundle_issuer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the instruction, PC and immediate width.
REQ-003 SHALL use one clock; reset is synchronous and active-high. Ports are listed below.
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- imem_req_o  out  1  instruction-memory read request
- imem_addr_o  out  32  base address of the 3-word read, word-aligned
- imem_rdata_0_i / _1_i / _2_i  in  32 each  words at addr, addr+4, addr+8; valid exactly one cycle after the request
- fetch_valid_o  out  3  per-slot valid toward the instruction buffer
- instruction_o_0..2  out  32 each  slot instruction
- pc_o_0..2  out  32 each  slot PC
- imm_o_0..2  out  32 each  slot branch/jump immediate
- branch_prediction_o_0..2  out  1 each  slot predicted-taken flag
- fetch_ready_i  in  1  buffer accepts the presented bundle this cycle
- flush_i  in  1  redirect request
- redirect_pc_i  in  32  new fetch PC, valid with flush_i

Function
REQ-004 SHALL implement a two-state FSM, RUN and HOLD, plus a pending_q flag (a response is due this cycle), a fetch_pc register and a hold bundle register.
REQ-005 SHALL form the presented bundle as follows:
- In RUN with pending_q=1: built from imem_rdata with base = pending_pc_q.
- In HOLD: taken from the hold register.
- Otherwise: no bundle, fetch_valid_o=000.
REQ-006 SHALL set slot k fields: instruction = rdata_k; pc = base+4k; imm = J-immediate if opcode 1101111, B-immediate if opcode 1100011, else 0; all sign-extended.
REQ-007 SHALL set prediction for slot k to 1 when:
- opcode is 1101111 (JAL), or
- opcode is 1100011 and imm bit 31 = 1 (backward branch taken).
REQ-008 SHALL clear fetch_valid_o for every slot after the first predicted-taken slot.
REQ-009 SHALL drive invalid slots as instruction 32'h00000013, pc 0, imm 0, prediction 0.
REQ-010 SHALL compute bundle next PC: first predicted slot's pc+imm if any slot is predicted, else base+12; 32-bit wrap-around.
REQ-011 SHALL treat a bundle as accepted in any cycle where fetch_ready_i=1 and fetch_valid_o!=0.
REQ-012 SHALL make fetch_valid_o and all slot outputs independent of fetch_ready_i (no combinational path).
REQ-013 SHALL handle RUN with pending_q=1 and fetch_ready_i=1 as follows:
- imem_req_o=1 with imem_addr_o = bundle next PC.
- pending_q stays 1 and pending_pc_q takes that address.
REQ-014 SHALL handle RUN with pending_q=1 and fetch_ready_i=0 as follows:
- imem_req_o=0.
- Capture the bundle into the hold register and load fetch_pc with the bundle next PC.
- pending_q<=0, state<=HOLD.
REQ-015 SHALL handle RUN with pending_q=0 as follows: imem_req_o=1 with imem_addr_o = fetch_pc, then pending_q<=1.
REQ-016 SHALL handle HOLD as follows:
- Present the held bundle, stable every cycle.
- On fetch_ready_i=1, issue imem_req_o=1 at fetch_pc in the same cycle, set pending_q<=1, state<=RUN (zero bubble).
REQ-017 SHALL give flush_i priority over all other events:
- In that cycle: fetch_valid_o=000, imem_req_o=0.
- Next state: fetch_pc <= {redirect_pc_i[31:2],2'b00}, pending_q<=0, state<=RUN.
- Any held or in-flight bundle is discarded and never presented.
REQ-018 SHALL keep imem_addr_o[1:0]=2'b00 at all times.
REQ-019 SHALL ignore imem_rdata in any cycle where pending_q=0.

Reset
REQ-020 SHALL, while reset=1 at a clock edge, set:
- state = RUN
- pending_q = 0
- fetch_pc = RESET_PC
- hold register = all-zero
REQ-021 SHALL drive imem_req_o=0 and fetch_valid_o=000 during any cycle with reset=1.
REQ-022 SHALL, after mid-operation reset, issue the first request at RESET_PC in the first cycle with reset=0, with no stale bundle presented.

Verification
REQ-023 SHALL pass: reset release with RESET_PC=0, memory returns three ADDIs, ready=1.
- Cycle 1: req addr 0x0.
- Cycle 2: fetch_valid_o=111, pcs 0x0/0x4/0x8, req addr 0xC.
REQ-024 SHALL pass: bundle at 0x100 with slot1 = 32'hFE000CE3 (beq x0,x0,-8).
- fetch_valid_o=011, branch_prediction_o_1=1, imm_o_1=32'hFFFFFFF8.
- Next req addr 0xFC.
REQ-025 SHALL pass: JAL +0x40 in slot0 at pc 0x20 -> fetch_valid_o=001, next req addr 0x60.
REQ-026 SHALL pass: bundle at 0x10 with ready=0 for 3 cycles, then ready=1.
- While ready=0: HOLD, imem_req_o=0, outputs identical.
- On ready=1: acceptance, with req addr 0x1C in the same cycle.
REQ-027 SHALL pass: flush_i with redirect_pc_i=0x203 during HOLD.
- That cycle: fetch_valid_o=000.
- Next cycle: req addr 0x200.
- The held bundle never reappears.
REQ-028 SHALL pass: reset asserted while pending_q=1 -> valid 000 during reset; first post-reset request at RESET_PC.
